ulpi_phy_reg_responder: RTL and testbench

PHY-side ULPI register-access responder, the opposite end of our link-side ULPI register read/write logic. It lets the FPGA emulate a ULPI PHY on the same 8-bit SDR bus (DIR/NXT/STP/data) for loopback and bench use. It holds DIR high through a startup window, then answers link TX CMD register reads and writes with correct NXT/DIR/turnaround sequencing. It backs them with a small register file that has set/clear aliases.

---
 rtl/ulpi_phy_reg_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_ulpi_phy_reg_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_phy_reg_responder.sv
// PHY-side ULPI register responder: holds DIR through a startup window, then
// answers link TX CMD register reads/writes from a small aliased register file.
module ulpi_phy_reg_responder #(
  parameter int          STARTUP_CYCLES = 64,
  parameter logic [15:0] VENDOR_ID      = 16'h0424,
  parameter logic [15:0] PRODUCT_ID     = 16'h0004
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       STP,
  output logic       DIR,
  output logic       NXT,
  inout  wire  [7:0] data,
  output logic [7:0] reg_fc,
  output logic [7:0] reg_ic,
  output logic [7:0] reg_otg,
  output logic       err
);

  localparam int CNT_W = $clog2(STARTUP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARTUP_CYCLES - 1);

  localparam logic [5:0] FC_BASE  = 6'h04;
  localparam logic [5:0] IC_BASE  = 6'h07;
  localparam logic [5:0] OTG_BASE = 6'h0A;
  localparam logic [5:0] SCR_BASE = 6'h16;
  localparam logic [5:0] EXT_ADDR = 6'h2F;

  localparam logic [7:0] FC_RST  = 8'h41;
  localparam logic [7:0] IC_RST  = 8'h00;
  localparam logic [7:0] OTG_RST = 8'h06;
  localparam logic [7:0] SCR_RST = 8'h00;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_RD_ACK,
    ST_RD_TA,
    ST_RD_DATA,
    ST_WR_ACK,
    ST_WR_DATA,
    ST_WR_STP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             nxt_q, nxt_d;
  logic             err_q, err_d;
  logic             oe_q, oe_d;
  logic [7:0]       dout_q, dout_d;
  logic [5:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       fc_q, fc_d;
  logic [7:0]       ic_q, ic_d;
  logic [7:0]       otg_q, otg_d;
  logic [7:0]       scr_q, scr_d;
  logic             commit;

  // base = plain write, base+1 = set bits, base+2 = clear bits
  function automatic logic [7:0] alias_wr(input logic [7:0] cur, input logic [5:0] addr,
                                          input logic [5:0] base, input logic [7:0] d,
                                          input logic en);
    alias_wr = cur;
    if (en) begin
      if (addr == base)              alias_wr = d;
      else if (addr == base + 6'd1)  alias_wr = cur | d;
      else if (addr == base + 6'd2)  alias_wr = cur & ~d;
    end
  endfunction

  function automatic logic [7:0] rd_mux(input logic [5:0] addr, input logic [7:0] fc,
                                        input logic [7:0] ic, input logic [7:0] otg,
                                        input logic [7:0] scr);
    case (addr)
      6'h00:               rd_mux = VENDOR_ID[7:0];
      6'h01:               rd_mux = VENDOR_ID[15:8];
      6'h02:               rd_mux = PRODUCT_ID[7:0];
      6'h03:               rd_mux = PRODUCT_ID[15:8];
      6'h04, 6'h05, 6'h06: rd_mux = fc;
      6'h07, 6'h08, 6'h09: rd_mux = ic;
      6'h0A, 6'h0B, 6'h0C: rd_mux = otg;
      6'h16, 6'h17, 6'h18: rd_mux = scr;
      default:             rd_mux = 8'h00;
    endcase
  endfunction

  assign commit = (state_q == ST_WR_STP) && STP;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    nxt_d   = nxt_q;
    err_d   = 1'b0;
    oe_d    = oe_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    // FC Reset bit only ever lives for the single cycle after its write
    fc_d  = alias_wr(fc_q & ~8'h20, addr_q, FC_BASE, wdata_q, commit);
    ic_d  = alias_wr(ic_q,  addr_q, IC_BASE,  wdata_q, commit);
    otg_d = alias_wr(otg_q, addr_q, OTG_BASE, wdata_q, commit);
    scr_d = alias_wr(scr_q, addr_q, SCR_BASE, wdata_q, commit);

    case (state_q)
      ST_STARTUP: begin
        dir_d = 1'b1;
        nxt_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          dir_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        dir_d = 1'b0;
        nxt_d = 1'b0;
        if (data[7]) begin
          if (data[5:0] == EXT_ADDR) begin
            err_d = 1'b1;
          end else begin
            addr_d  = data[5:0];
            nxt_d   = 1'b1;
            state_d = data[6] ? ST_RD_ACK : ST_WR_ACK;
          end
        end
      end
      ST_RD_ACK: begin
        nxt_d = 1'b0;
        if (STP) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          dir_d   = 1'b1;
          state_d = ST_RD_TA;
        end
      end
      ST_RD_TA: begin
        oe_d    = 1'b1;
        dout_d  = rd_mux(addr_q, fc_q, ic_q, otg_q, scr_q);
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        oe_d    = 1'b0;
        dir_d   = 1'b0;
        state_d = ST_IDLE;
      end
      ST_WR_ACK: begin
        if (STP) begin
          err_d   = 1'b1;
          nxt_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        nxt_d = 1'b0;
        if (STP) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wdata_d = data;
          state_d = ST_WR_STP;
        end
      end
      ST_WR_STP: begin
        err_d   = ~STP;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_STARTUP;
        dir_d   = 1'b1;
        nxt_d   = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STARTUP;
      cnt_q   <= '0;
      dir_q   <= 1'b1;
      nxt_q   <= 1'b0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      addr_q  <= 6'h00;
      wdata_q <= 8'h00;
      fc_q    <= FC_RST;
      ic_q    <= IC_RST;
      otg_q   <= OTG_RST;
      scr_q   <= SCR_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      nxt_q   <= nxt_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fc_q    <= fc_d;
      ic_q    <= ic_d;
      otg_q   <= otg_d;
      scr_q   <= scr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_data_drv
      assign data[gi] = oe_q ? dout_q[gi] : 1'bz;
    end
  endgenerate

  assign DIR     = dir_q;
  assign NXT     = nxt_q;
  assign err     = err_q;
  assign reg_fc  = fc_q;
  assign reg_ic  = ic_q;
  assign reg_otg = otg_q;

endmodule

// File: tb/tb_ulpi_phy_reg_responder.sv
// Bench for ulpi_phy_reg_responder: acts as the ULPI link, scoreboards read data.
module tb_ulpi_phy_reg_responder;

  localparam int SC = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       STP;
  logic       DIR;
  logic       NXT;
  wire  [7:0] data;
  logic [7:0] reg_fc;
  logic [7:0] reg_ic;
  logic [7:0] reg_otg;
  logic       err;

  logic [7:0] tb_dout;
  logic       tb_oe;
  assign data = tb_oe ? tb_dout : 8'hzz;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_fc, m_ic, m_otg, m_scr;

  ulpi_phy_reg_responder #(
    .STARTUP_CYCLES(SC),
    .VENDOR_ID(16'h0424),
    .PRODUCT_ID(16'h0004)
  ) dut (
    .clk(clk),
    .reset(reset),
    .STP(STP),
    .DIR(DIR),
    .NXT(NXT),
    .data(data),
    .reg_fc(reg_fc),
    .reg_ic(reg_ic),
    .reg_otg(reg_otg),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_fc  = 8'h41;
    m_ic  = 8'h00;
    m_otg = 8'h06;
    m_scr = 8'h00;
  endtask

  task automatic model_wr(input logic [5:0] a, input logic [7:0] d);
    case (a)
      6'h04: m_fc  = d;
      6'h05: m_fc  = m_fc | d;
      6'h06: m_fc  = m_fc & ~d;
      6'h07: m_ic  = d;
      6'h08: m_ic  = m_ic | d;
      6'h09: m_ic  = m_ic & ~d;
      6'h0A: m_otg = d;
      6'h0B: m_otg = m_otg | d;
      6'h0C: m_otg = m_otg & ~d;
      6'h16: m_scr = d;
      6'h17: m_scr = m_scr | d;
      6'h18: m_scr = m_scr & ~d;
      default: ;
    endcase
  endtask

  function automatic logic [7:0] model_rd(input logic [5:0] a);
    if (a == 6'h00) return 8'h24;
    if (a == 6'h01) return 8'h04;
    if (a == 6'h02) return 8'h04;
    if (a == 6'h03) return 8'h00;
    if (a >= 6'h04 && a <= 6'h06) return m_fc;
    if (a >= 6'h07 && a <= 6'h09) return m_ic;
    if (a >= 6'h0A && a <= 6'h0C) return m_otg;
    if (a >= 6'h16 && a <= 6'h18) return m_scr;
    return 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Releases reset on a clean cycle boundary and measures the DIR-high window.
  task automatic check_startup(input string tag);
    int n;
    @(posedge clk);
    #1;
    reset = 1'b1;
    n = 0;
    while (DIR === 1'b1 && n < 4 * SC) begin
      step();
      n++;
    end
    tests_run++;
    if (n != SC) begin
      tests_failed++;
      $display("FAIL %s startup_len: DIR high for %0d cycles, required %0d", tag, n, SC);
    end
    tests_run++;
    if (DIR !== 1'b0 || NXT !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s post_startup: DIR=%b NXT=%b err=%b, required 0 0 0", tag, DIR, NXT, err);
    end
    $display("[TB] startup %s: DIR high %0d cycles", tag, n);
  endtask

  task automatic do_read(input logic [5:0] a, input string tag);
    logic [7:0] e;
    exp_q.push_back(model_rd(a));
    tb_dout = {2'b11, a};
    tb_oe   = 1'b1;
    step();
    tb_oe = 1'b0;
    tests_run++;
    if (NXT !== 1'b1 || DIR !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s rd_ack: NXT=%b DIR=%b, required NXT=1 DIR=0", tag, NXT, DIR);
    end
    step();
    tests_run++;
    if (DIR !== 1'b1 || NXT !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s rd_ta: DIR=%b NXT=%b, required DIR=1 NXT=0", tag, DIR, NXT);
    end
    step();
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s rd_data: scoreboard empty, got %02h", tag, data);
    end else begin
      e = exp_q.pop_front();
      if (DIR !== 1'b1 || data !== e) begin
        tests_failed++;
        $display("FAIL %s rd_data: DIR=%b data=%02h, required DIR=1 data=%02h", tag, DIR, data, e);
      end
    end
    $display("[TB] read  %s addr=%02h data=%02h", tag, a, data);
    step();
    tests_run++;
    if (DIR !== 1'b0 || NXT !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s rd_end: DIR=%b NXT=%b, required DIR=0 NXT=0", tag, DIR, NXT);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input logic stp, input string tag);
    tb_dout = {2'b10, a};
    tb_oe   = 1'b1;
    STP     = 1'b0;
    step();
    tb_dout = d;
    tests_run++;
    if (NXT !== 1'b1 || DIR !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s wr_ack: NXT=%b DIR=%b, required NXT=1 DIR=0", tag, NXT, DIR);
    end
    step();
    tests_run++;
    if (NXT !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s wr_data: NXT=%b, required 1", tag, NXT);
    end
    step();
    tb_oe = 1'b0;
    STP   = stp;
    tests_run++;
    if (NXT !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s wr_stp: NXT=%b, required 0", tag, NXT);
    end
    step();
    STP = 1'b0;
    if (stp) model_wr(a, d);
    tests_run++;
    if (err !== ~stp) begin
      tests_failed++;
      $display("FAIL %s wr_err: err=%b, required %b", tag, err, ~stp);
    end
    tests_run++;
    if (reg_fc !== m_fc || reg_ic !== m_ic || reg_otg !== m_otg) begin
      tests_failed++;
      $display("FAIL %s wr_regs: fc=%02h ic=%02h otg=%02h, required %02h %02h %02h",
               tag, reg_fc, reg_ic, reg_otg, m_fc, m_ic, m_otg);
    end
    m_fc[5] = 1'b0;
    $display("[TB] write %s addr=%02h data=%02h stp=%b", tag, a, d, stp);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    STP   = 1'b0;
    tb_oe = 1'b0;
    tb_dout = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (DIR !== 1'b1 || NXT !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: DIR=%b NXT=%b err=%b, required 1 0 0", DIR, NXT, err);
    end
    tests_run++;
    if (reg_fc !== 8'h41 || reg_ic !== 8'h00 || reg_otg !== 8'h06) begin
      tests_failed++;
      $display("FAIL reset_regs: fc=%02h ic=%02h otg=%02h, required 41 00 06", reg_fc, reg_ic, reg_otg);
    end
    check_startup("initial");
  endtask

  task automatic test_read_ids();
    do_read(6'h00, "vid_lo");
    do_read(6'h03, "pid_hi");
    do_read(6'h01, "vid_hi");
    do_read(6'h02, "pid_lo");
    do_read(6'h3A, "unmapped");
  endtask

  task automatic test_write_alias();
    do_write(6'h07, 8'h05, 1'b1, "ic_write");
    do_write(6'h09, 8'h01, 1'b1, "ic_clear");
    do_read(6'h08, "ic_read");
    do_write(6'h0B, 8'h30, 1'b1, "otg_set");
    do_write(6'h0C, 8'h02, 1'b1, "otg_clear");
    do_write(6'h01, 8'hFF, 1'b1, "ro_write");
    do_read(6'h01, "ro_read");
  endtask

  task automatic test_fc_selfclear();
    do_write(6'h04, 8'h20, 1'b1, "fc_reset");
    step();
    tests_run++;
    if (reg_fc !== 8'h00) begin
      tests_failed++;
      $display("FAIL fc_selfclear: reg_fc=%02h, required 00", reg_fc);
    end
    do_read(6'h05, "fc_read");
  endtask

  task automatic test_write_no_stp();
    do_write(6'h16, 8'hA5, 1'b0, "scr_nostp");
    step();
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL nostp_err_width: err=%b, required 0", err);
    end
    do_read(6'h16, "scr_read");
  endtask

  task automatic test_ext_and_ignored();
    tb_dout = 8'hEF;
    tb_oe   = 1'b1;
    step();
    tb_oe = 1'b0;
    tests_run++;
    if (NXT !== 1'b0 || err !== 1'b1 || DIR !== 1'b0) begin
      tests_failed++;
      $display("FAIL ext_addr: NXT=%b err=%b DIR=%b, required 0 1 0", NXT, err, DIR);
    end
    step();
    tests_run++;
    if (err !== 1'b0 || NXT !== 1'b0) begin
      tests_failed++;
      $display("FAIL ext_err_width: err=%b NXT=%b, required 0 0", err, NXT);
    end
    $display("[TB] cmd   ext_addr EF");
    tb_dout = 8'h5C;
    tb_oe   = 1'b1;
    step();
    tb_oe = 1'b0;
    tests_run++;
    if (NXT !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_cmd: NXT=%b err=%b, required 0 0", NXT, err);
    end
    $display("[TB] cmd   ignored 5C");
  endtask

  task automatic test_abort();
    tb_dout = 8'h96;
    tb_oe   = 1'b1;
    step();
    tb_dout = 8'h77;
    STP = 1'b1;
    step();
    STP   = 1'b0;
    tb_oe = 1'b0;
    tests_run++;
    if (err !== 1'b1 || NXT !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_abort: err=%b NXT=%b, required 1 0", err, NXT);
    end
    $display("[TB] write abort addr=16 in WR_ACK");
    do_read(6'h16, "abort_read");
  endtask

  task automatic test_back_to_back();
    do_write(6'h17, 8'h3C, 1'b1, "b2b_set");
    do_read(6'h18, "b2b_rd_scr");
    do_read(6'h00, "b2b_rd_vid");
    do_write(6'h0A, 8'h81, 1'b1, "b2b_otg");
    do_write(6'h06, 8'h01, 1'b1, "b2b_fc_clr");
    do_read(6'h0B, "b2b_rd_otg");
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    exp_q.push_back(model_rd(6'h07));
    tb_dout = {2'b11, 6'h07};
    tb_oe   = 1'b1;
    step();
    tb_oe = 1'b0;
    step();
    step();
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL mid_rd_data: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (DIR !== 1'b1 || data !== e) begin
        tests_failed++;
        $display("FAIL mid_rd_data: DIR=%b data=%02h, required 1 %02h", DIR, data, e);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (DIR !== 1'b1 || NXT !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: DIR=%b NXT=%b err=%b, required 1 0 0", DIR, NXT, err);
    end
    model_reset();
    tests_run++;
    if (reg_ic !== m_ic || reg_fc !== m_fc || reg_otg !== m_otg) begin
      tests_failed++;
      $display("FAIL mid_reset_regs: fc=%02h ic=%02h otg=%02h, required %02h %02h %02h",
               reg_fc, reg_ic, reg_otg, m_fc, m_ic, m_otg);
    end
    $display("[TB] reset asserted during RD_DATA");
    repeat (2) @(posedge clk);
    check_startup("mid_reset");
    do_read(6'h07, "post_reset_ic");
  endtask

  initial begin
    test_reset();
    test_read_ids();
    test_write_alias();
    test_fc_selfclear();
    test_write_no_stp();
    test_ext_and_ignored();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
